// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals of the unified memory arbiter.
// The master modport is the arbiter's view. The slave modport is the requesters' and the memory's view.
interface unified_mem_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        timeout_err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_instr, if_valid, d_rdata, d_valid, stall,
               mem_req, mem_we, mem_addr, mem_wdata, timeout_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_instr, if_valid, d_rdata, d_valid, stall,
               mem_req, mem_we, mem_addr, mem_wdata, timeout_err
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and LDUR/STUR.
// Data requests have priority. A starvation counter and a sticky timeout watchdog guard the port.
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_r;
    logic [SW-1:0] starve_r;
    logic [WW-1:0] wait_r;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [63:0]   mem_addr_r;
    logic [63:0]   mem_wdata_r;
    logic [31:0]   if_instr_r;
    logic          if_valid_r;
    logic [63:0]   d_rdata_r;
    logic          d_valid_r;
    logic          timeout_err_r;
    logic          force_fetch_s;
    logic [31:0]   fetch_word_s;
    logic          stall_s;

    // Fetch forcing and selection of the 32-bit half addressed by the latched fetch address.
    always_comb begin
        force_fetch_s = bus.if_req && (starve_r == STARVE_MAX);
        if (mem_addr_r[2]) begin
            fetch_word_s = bus.mem_rdata[63:32];
        end else begin
            fetch_word_s = bus.mem_rdata[31:0];
        end
    end

    // Pipeline stall: in IDLE it follows the raw requests so the stage freezes in the cycle it asks.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  stall_s = bus.if_req || bus.d_req;
                ST_DATA:  stall_s = 1'b1;
                ST_FETCH: stall_s = 1'b1;
                ST_DONE:  stall_s = 1'b0;
                default:  stall_s = 1'b0;
            endcase
        end
    end

    // Arbitration FSM, memory handshake registers, result capture and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            starve_r      <= '0;
            wait_r        <= '0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 64'd0;
            mem_wdata_r   <= 64'd0;
            if_instr_r    <= 32'd0;
            if_valid_r    <= 1'b0;
            d_rdata_r     <= 64'd0;
            d_valid_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.d_req && !force_fetch_s) begin
                        state_r     <= ST_DATA;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.d_we;
                        mem_addr_r  <= bus.d_addr;
                        mem_wdata_r <= bus.d_we ? bus.d_wdata : 64'd0;
                        wait_r      <= '0;
                        starve_r    <= bus.if_req ? (starve_r + SW'(1)) : '0;
                    end else if (bus.if_req) begin
                        state_r     <= ST_FETCH;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= bus.if_addr;
                        mem_wdata_r <= 64'd0;
                        wait_r      <= '0;
                        starve_r    <= '0;
                    end else begin
                        starve_r <= '0;
                    end
                end
                ST_DATA, ST_FETCH: begin
                    if (bus.mem_ready) begin
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                        if (state_r == ST_DATA) begin
                            d_valid_r <= 1'b1;
                            if (!mem_we_r) begin
                                d_rdata_r <= bus.mem_rdata;
                            end
                        end else begin
                            if_valid_r <= 1'b1;
                            if_instr_r <= fetch_word_s;
                        end
                    end else if (wait_r == WAIT_LAST) begin
                        // Abort: the requester still gets its pulse, with zero data, so the pipeline drains.
                        mem_req_r     <= 1'b0;
                        state_r       <= ST_DONE;
                        timeout_err_r <= 1'b1;
                        if (state_r == ST_DATA) begin
                            d_valid_r <= 1'b1;
                            d_rdata_r <= 64'd0;
                        end else begin
                            if_valid_r <= 1'b1;
                            if_instr_r <= 32'd0;
                        end
                    end else begin
                        wait_r <= wait_r + WW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.if_instr    = if_instr_r;
    assign bus.if_valid    = if_valid_r;
    assign bus.d_rdata     = d_rdata_r;
    assign bus.d_valid     = d_valid_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.stall       = stall_s;
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates a single-ported, variable-latency unified memory between the instruction-fetch stage and the memory stage (LDUR/STUR) of the pipelined CPU. Grants one requester at a time, drives the memory handshake, returns read data with a one-cycle valid pulse, and asserts a pipeline-wide stall while any access is outstanding. Includes data-priority arbitration with a fetch anti-starvation counter and a sticky timeout watchdog.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced next.
- MAX_WAIT, 16: cycles mem_req may stay high without mem_ready before the access is aborted.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, and the reset is synchronous and active-high.
- if_req  input  1  fetch request; held with if_addr stable until if_valid.
- if_addr  input  64  byte address of instruction; bit 2 selects word half.
- if_instr  output  32  fetched instruction, valid with if_valid.
- if_valid  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_valid.
- d_we  input  1  1 = STUR write, 0 = LDUR read.
- d_addr  input  64  data byte address.
- d_wdata  input  64  store data.
- d_rdata  output  64  load data, valid with d_valid.
- d_valid  output  1  one-cycle completion pulse for data.
- stall  output  1  freeze pipeline registers.
- mem_req  output  1  memory access request (registered).
- mem_we  output  1  memory write enable (registered).
- mem_addr  output  64  memory address (registered).
- mem_wdata  output  64  memory write data (registered; 0 on reads).
- mem_rdata  input  64  memory read data, valid when mem_ready.
- mem_ready  input  1  memory completes current access this cycle.
- timeout_err  output  1  sticky watchdog error flag.

## Operation
- States: IDLE, DATA, FETCH, DONE.
- IDLE: if d_req and not forced-fetch -> latch d_we/d_addr/d_wdata into mem_* regs, mem_req=1, go DATA. Else if if_req -> latch if_addr, mem_we=0, mem_wdata=0, go FETCH. Else stay.
- Forced-fetch: starve counter (width ≥ clog2(STARVE_LIMIT+1)) increments on each data grant made while if_req high; clears on any fetch grant or when if_req low in IDLE. When counter == STARVE_LIMIT and if_req high, IDLE grants fetch even if d_req high.
- DATA/FETCH: hold mem_* stable. On mem_ready: capture mem_rdata (DATA read -> d_rdata; FETCH -> if_instr = addr[2] ? rdata[63:32] : rdata[31:0]), drop mem_req, go DONE. Stores leave d_rdata unchanged.
- Watchdog: wait counter clears on grant, increments each DATA/FETCH cycle without mem_ready; on reaching MAX_WAIT-1 without ready: set timeout_err, drop mem_req, capture zeros into the relevant data output, go DONE.
- DONE: pulse d_valid (came from DATA) or if_valid (came from FETCH) for exactly one cycle; requests ignored; next state IDLE.
- stall = 1 in DATA and FETCH; 1 in IDLE when if_req or d_req; 0 in DONE; forced 0 while reset high.
- timeout_err cleared only by reset.

## Timing
- Reset (sync): state IDLE, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_instr, if_valid, d_rdata, d_valid, timeout_err), counters 0. Reset mid-access aborts it; no valid pulse issued.
- Grant at IDLE edge N -> mem_req high from cycle N+1.
- mem_ready seen in cycle M (M ≥ N+1) -> valid pulse and data in cycle M+1 (DONE) -> IDLE at M+2.
- Minimum access: 3 cycles per access (grant, ready, DONE); back-to-back throughput one access per 3 cycles with zero-wait memory.
- mem_ready while mem_req low (IDLE/DONE) is ignored.
- Simultaneous d_req and if_req in IDLE: data wins unless forced-fetch.
- Requester may raise a new request during its DONE cycle; sampled in next IDLE.

## Test plan
- Fetch if_addr=0x104, mem_rdata=0xAABBCCDD_11223344, mem_ready 2 cycles after mem_req -> if_instr=0xAABBCCDD, single if_valid pulse, stall high until DONE.
- d_req store d_addr=0x40 d_wdata=0xDEADBEEF, zero-wait memory -> mem_we=1, mem_addr=0x40, d_valid one cycle, d_rdata unchanged.
- d_req and if_req asserted same cycle -> DATA granted first, FETCH granted at next IDLE.
- d_req held continuously with if_req pending, STARVE_LIMIT=4 -> 4 data grants then 1 fetch grant.
- mem_ready never asserted, MAX_WAIT=16 -> mem_req drops after 16 cycles, timeout_err=1 and stays 1, valid pulse with data 0.
- reset asserted during FETCH wait -> next cycle all outputs 0, state IDLE, no if_valid.
